// File: rtl/hist_pkg.sv
// Shared constants, word layout and state encoding for the hit-counter readout.
package hist_pkg;

    localparam int NSLICE = 32;
    localparam int CW     = 16;
    localparam int TW     = 24;
    localparam int IW     = 5;

    // Output word layout: {sat, idx, count}
    localparam int CNT_LSB = 0;
    localparam int IDX_LSB = CW;
    localparam int SAT_BIT = CW + IW;

    typedef enum logic [2:0] {
        IDLE,
        ACQ,
        SETTLE,
        PRESENT,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/acq_timer.sv
// Loadable down-counter that times the acquisition window.
// expire_o flags the last cycle of the window (count == 1).
module acq_timer
    import hist_pkg::*;
#(
    parameter int TW = hist_pkg::TW
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    input  logic          dec_i,
    output logic          expire_o
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Load wins over decrement; the counter parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == TW'(1));

endmodule

// File: rtl/hist_readout.sv
// Acquisition control and serial unload of the chained slice hit counters.
// A frame runs ACQ (count enable) -> SETTLE -> PRESENT/SHIFT per slice -> DONE,
// emitting one {sat, idx, count} word per slice, highest slice first.
module hist_readout
    import hist_pkg::*;
#(
    parameter int NSLICE = hist_pkg::NSLICE,
    parameter int CW     = hist_pkg::CW,
    parameter int TW     = hist_pkg::TW,
    parameter int IW     = hist_pkg::IW
) (
    input  logic           clk,
    input  logic           clr_n,
    input  logic           start,
    input  logic           stop,
    input  logic           clr_hist,
    input  logic [TW-1:0]  window_len,
    input  logic [CW-1:0]  hc_q,
    input  logic           hc_max,
    output logic           hc_ce,
    output logic           hc_ld,
    output logic           hc_clr,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [IW+CW:0] m_data,
    output logic           busy,
    output logic           done
);

    state_e        state_q;
    logic          settle_q;
    logic          sat_q;
    logic [IW-1:0] idx_q;
    logic          hc_ce_q;
    logic          hc_ld_q;
    logic          hc_clr_q;
    logic          m_valid_q;
    logic          busy_q;
    logic          done_q;

    logic          tmr_load;
    logic          tmr_dec;
    logic          tmr_expire;

    assign tmr_load = (state_q == IDLE) && start && !clr_hist && (window_len != '0);
    assign tmr_dec  = (state_q == ACQ);

    acq_timer #(
        .TW(TW)
    ) u_timer (
        .clk        (clk),
        .clr_n      (clr_n),
        .load_i     (tmr_load),
        .load_val_i (window_len),
        .dec_i      (tmr_dec),
        .expire_o   (tmr_expire)
    );

    // Frame sequencer; every chain strobe and stream flag is a registered output.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            settle_q  <= 1'b0;
            sat_q     <= 1'b0;
            idx_q     <= '0;
            hc_ce_q   <= 1'b0;
            hc_ld_q   <= 1'b0;
            hc_clr_q  <= 1'b0;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            hc_clr_q <= 1'b0;
            hc_ld_q  <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clr_hist) begin
                        // Clear has priority; a coincident start is dropped.
                        hc_clr_q <= 1'b1;
                    end else if (start) begin
                        sat_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        settle_q <= 1'b0;
                        if (window_len != '0) begin
                            hc_ce_q <= 1'b1;
                            state_q <= ACQ;
                        end else begin
                            state_q <= SETTLE;
                        end
                    end
                end
                ACQ: begin
                    if (hc_max) begin
                        sat_q <= 1'b1;
                    end
                    if (tmr_expire || stop || hc_max) begin
                        hc_ce_q  <= 1'b0;
                        settle_q <= 1'b0;
                        state_q  <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Two idle cycles let the last latched hit reach the counters.
                    if (!settle_q) begin
                        settle_q <= 1'b1;
                    end else begin
                        sat_q     <= sat_q | hc_max;
                        idx_q     <= IW'(NSLICE - 1);
                        m_valid_q <= 1'b1;
                        state_q   <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        hc_ld_q   <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (idx_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q     <= idx_q - IW'(1);
                        m_valid_q <= 1'b1;
                        state_q   <= PRESENT;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign hc_ce   = hc_ce_q;
    assign hc_ld   = hc_ld_q;
    assign hc_clr  = hc_clr_q;
    assign m_valid = m_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

    // The count field is the chain's own output register: it already holds the
    // next slice right after the shift edge, so no extra capture stage is
    // needed for back-to-back words. It is frozen during PRESENT because the
    // chain neither counts nor shifts there, and gated to zero outside it.
    assign m_data = {sat_q, idx_q, (m_valid_q ? hc_q : {CW{1'b0}})};

endmodule

// File: tb/tb_hist_readout.sv
`timescale 1ns/1ps
module tb_hist_readout;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start, stop, clr_hist, m_ready;
    logic [23:0] window_len;
    logic [15:0] hc_q;
    logic        hc_max;
    logic        hc_ce, hc_ld, hc_clr, m_valid, busy, done;
    logic [21:0] m_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hist_readout dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .start      (start),
        .stop       (stop),
        .clr_hist   (clr_hist),
        .window_len (window_len),
        .hc_q       (hc_q),
        .hc_max     (hc_max),
        .hc_ce      (hc_ce),
        .hc_ld      (hc_ld),
        .hc_clr     (hc_clr),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy),
        .done       (done)
    );

    // ---------------- hit-counter chain model ----------------
    logic [15:0] cnt     [0:31];
    logic [15:0] pre_val [0:31];
    int          tgt     [0:31];
    int          used    [0:31];
    logic        pre_en, arm;

    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < 32; i++) cnt[i] <= pre_val[i];
        end else if (hc_clr) begin
            for (int i = 0; i < 32; i++) cnt[i] <= 16'h0;
        end else if (hc_ld) begin
            cnt[0] <= 16'h0;
            for (int i = 1; i < 32; i++) cnt[i] <= cnt[i-1];
        end else if (hc_ce) begin
            for (int i = 0; i < 32; i++)
                if (used[i] < tgt[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'h1;
        end
        for (int i = 0; i < 32; i++) begin
            if (arm) used[i] <= 0;
            else if (hc_ce && used[i] < tgt[i]) used[i] <= used[i] + 1;
        end
    end

    always_comb begin
        hc_max = 1'b0;
        for (int i = 0; i < 32; i++) if (cnt[i] == 16'hFFFF) hc_max = 1'b1;
    end
    assign hc_q = cnt[31];

    // ---------------- frame capture ----------------
    int          nwords;
    logic [4:0]  w_idx [0:39];
    logic [15:0] w_cnt [0:39];
    logic        w_sat [0:39];
    int          ce_cyc, ld_cyc, done_cyc, clr_cyc, overlap, unstable, valid_cyc, tmo;
    logic [15:0] exp_cnt [0:31];
    logic        exp_sat;

    task automatic load_chain();
        @(negedge clk);
        for (int i = 0; i < 32; i++) pre_val[i] = exp_cnt[i];
        pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic arm_hits();
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    // Start a frame and run it to done (or abort at a given idx), recording
    // accepted words and per-cycle strobe statistics.
    task automatic run_frame(input int len, input int ready_pct, input int stop_at,
                             input int junk_at, input int abort_idx);
        logic        stalled;
        logic [21:0] held;
        bit          fin;
        nwords = 0; ce_cyc = 0; ld_cyc = 0; done_cyc = 0; clr_cyc = 0;
        overlap = 0; unstable = 0; valid_cyc = 0; tmo = 0;
        stalled = 1'b0; held = '0; fin = 0;
        for (int k = 0; k < 40; k++) begin w_idx[k] = '0; w_cnt[k] = '0; w_sat[k] = 1'b0; end
        @(negedge clk);
        start = 1'b1;
        window_len = len[23:0];
        m_ready = 1'b0;
        for (int n = 1; n < 3000 && !fin; n++) begin
            @(negedge clk);
            start = 1'b0; stop = 1'b0; clr_hist = 1'b0;
            if (hc_ce) ce_cyc++;
            if (hc_ld) ld_cyc++;
            if (done) done_cyc++;
            if (hc_clr) clr_cyc++;
            if (hc_ce && hc_ld) overlap++;
            if (m_valid) valid_cyc++;
            if (stalled && (m_data !== held || m_valid !== 1'b1)) unstable++;
            if (abort_idx >= 0 && m_valid && m_data[20:16] == abort_idx[4:0]) begin
                m_ready = 1'b0;
                #1 clr_n = 1'b0;
                #1;
                fin = 1;
            end else begin
                if (done) fin = 1;
                m_ready = ($urandom_range(0, 99) < ready_pct);
                if (m_valid && m_ready && nwords < 40) begin
                    w_sat[nwords] = m_data[21];
                    w_idx[nwords] = m_data[20:16];
                    w_cnt[nwords] = m_data[15:0];
                    nwords++;
                end
                stalled = m_valid && !m_ready;
                held = m_data;
                if (n == stop_at) stop = 1'b1;
                if (n == junk_at) begin start = 1'b1; window_len = 24'd5; clr_hist = 1'b1; end
            end
        end
        if (!fin) tmo = 1;
        start = 1'b0; stop = 1'b0; clr_hist = 1'b0; m_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clr_n = 1'b0; start = 1'b0; stop = 1'b0; clr_hist = 1'b0; m_ready = 1'b0;
        window_len = 24'd0; arm = 1'b1; pre_en = 1'b1;
        for (int i = 0; i < 32; i++) begin pre_val[i] = 16'h0; tgt[i] = 0; end
        repeat (3) @(negedge clk);
        n_checks++; if ({hc_ce, hc_ld, hc_clr, m_valid, busy, done} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: {ce,ld,clr,valid,busy,done}=%b want 000000",
                               {hc_ce, hc_ld, hc_clr, m_valid, busy, done}); end
        n_checks++; if (m_data !== 22'h0) begin
            n_fail++; $display("FAIL reset_data: m_data=%h want 0", m_data); end
        arm = 1'b0; pre_en = 1'b0;
        clr_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: busy=%b valid=%b want 0 0", busy, m_valid); end
        clr_hist = 1'b1;
        clr_cyc = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            clr_hist = 1'b0;
            if (hc_clr) clr_cyc++;
        end
        n_checks++; if (clr_cyc !== 1) begin
            n_fail++; $display("FAIL reset_clr_hist: hc_clr cycles=%0d want 1", clr_cyc); end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 32; i++) begin tgt[i] = 0; exp_cnt[i] = 16'h0; end
        tgt[0] = 3; tgt[5] = 7; tgt[31] = 1;
        exp_cnt[0] = 16'd3; exp_cnt[5] = 16'd7; exp_cnt[31] = 16'd1;
        exp_sat = 1'b0;
        arm_hits();
        run_frame(100, 100, -1, -1, -1);
        n_checks++; if (tmo !== 0) begin n_fail++; $display("FAIL basic_timeout: tmo=%0d want 0", tmo); end
        n_checks++; if (ce_cyc !== 100) begin n_fail++; $display("FAIL basic_ce: cycles=%0d want 100", ce_cyc); end
        n_checks++; if (nwords !== 32) begin n_fail++; $display("FAIL basic_nwords: %0d want 32", nwords); end
        n_checks++; if (ld_cyc !== 32) begin n_fail++; $display("FAIL basic_ld: %0d want 32", ld_cyc); end
        n_checks++; if (done_cyc !== 1) begin n_fail++; $display("FAIL basic_done: %0d want 1", done_cyc); end
        n_checks++; if (overlap !== 0) begin n_fail++; $display("FAIL basic_ce_ld_overlap: %0d want 0", overlap); end
        n_checks++; if (valid_cyc !== 32) begin n_fail++; $display("FAIL basic_throughput: valid cycles=%0d want 32", valid_cyc); end
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (w_idx[k] !== 5'(31 - k) || w_cnt[k] !== exp_cnt[31 - k] || w_sat[k] !== exp_sat) begin
                n_fail++;
                $display("FAIL basic_word%0d: got sat=%0b idx=%0d cnt=%h want sat=%0b idx=%0d cnt=%h",
                         k, w_sat[k], w_idx[k], w_cnt[k], exp_sat, 31 - k, exp_cnt[31 - k]);
            end
        end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL basic_idle_after: busy=%b done=%b want 0 0", busy, done); end
        // Second unload: chain was zeroed by the first.
        run_frame(0, 100, -1, -1, -1);
        n_checks++; if (ce_cyc !== 0 || nwords !== 32) begin
            n_fail++; $display("FAIL basic_second_frame: ce=%0d words=%0d want 0 32", ce_cyc, nwords); end
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (w_idx[k] !== 5'(31 - k) || w_cnt[k] !== 16'h0 || w_sat[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_zero_word%0d: got sat=%0b idx=%0d cnt=%h want sat=0 idx=%0d cnt=0000",
                         k, w_sat[k], w_idx[k], w_cnt[k], 31 - k);
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 32; i++) begin tgt[i] = 0; exp_cnt[i] = 16'(i * 1000 + 7); end
        load_chain();
        run_frame(0, 40, -1, -1, -1);
        n_checks++; if (tmo !== 0) begin n_fail++; $display("FAIL stall_timeout: tmo=%0d want 0", tmo); end
        n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL stall_stable: changes=%0d want 0", unstable); end
        n_checks++; if (ld_cyc !== 32) begin n_fail++; $display("FAIL stall_ld: %0d want 32", ld_cyc); end
        n_checks++; if (nwords !== 32) begin n_fail++; $display("FAIL stall_nwords: %0d want 32", nwords); end
        n_checks++; if (valid_cyc <= 32) begin n_fail++; $display("FAIL stall_exercised: valid cycles=%0d want >32", valid_cyc); end
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (w_idx[k] !== 5'(31 - k) || w_cnt[k] !== exp_cnt[31 - k] || w_sat[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_word%0d: got sat=%0b idx=%0d cnt=%h want sat=0 idx=%0d cnt=%h",
                         k, w_sat[k], w_idx[k], w_cnt[k], 31 - k, exp_cnt[31 - k]);
            end
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 32; i++) begin tgt[i] = 0; exp_cnt[i] = 16'h0; end
        exp_cnt[2] = 16'hFFF0;
        load_chain();
        tgt[2] = 100; tgt[7] = 4;
        arm_hits();
        exp_cnt[2] = 16'hFFFF; exp_cnt[7] = 16'd4;
        run_frame(100, 100, -1, -1, -1);
        n_checks++; if (ce_cyc !== 16) begin n_fail++; $display("FAIL sat_early_exit: ce cycles=%0d want 16", ce_cyc); end
        n_checks++; if (nwords !== 32) begin n_fail++; $display("FAIL sat_nwords: %0d want 32", nwords); end
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (w_idx[k] !== 5'(31 - k) || w_cnt[k] !== exp_cnt[31 - k] || w_sat[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_word%0d: got sat=%0b idx=%0d cnt=%h want sat=1 idx=%0d cnt=%h",
                         k, w_sat[k], w_idx[k], w_cnt[k], 31 - k, exp_cnt[31 - k]);
            end
        end
    endtask

    task automatic test_zero_window();
        for (int i = 0; i < 32; i++) begin tgt[i] = 0; exp_cnt[i] = 16'(16'hA000 + i); end
        load_chain();
        run_frame(0, 100, -1, -1, -1);
        n_checks++; if (ce_cyc !== 0) begin n_fail++; $display("FAIL zero_win_ce: cycles=%0d want 0", ce_cyc); end
        n_checks++; if (nwords !== 32 || done_cyc !== 1) begin
            n_fail++; $display("FAIL zero_win_frame: words=%0d done=%0d want 32 1", nwords, done_cyc); end
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (w_idx[k] !== 5'(31 - k) || w_cnt[k] !== exp_cnt[31 - k] || w_sat[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_win_word%0d: got sat=%0b idx=%0d cnt=%h want sat=0 idx=%0d cnt=%h",
                         k, w_sat[k], w_idx[k], w_cnt[k], 31 - k, exp_cnt[31 - k]);
            end
        end
    endtask

    task automatic test_stop();
        for (int i = 0; i < 32; i++) tgt[i] = 0;
        run_frame(100, 100, 10, -1, -1);
        n_checks++; if (ce_cyc !== 10) begin n_fail++; $display("FAIL stop_ce: cycles=%0d want 10", ce_cyc); end
        n_checks++; if (nwords !== 32 || ld_cyc !== 32) begin
            n_fail++; $display("FAIL stop_frame: words=%0d ld=%0d want 32 32", nwords, ld_cyc); end
    endtask

    task automatic test_reset_abort();
        for (int i = 0; i < 32; i++) begin tgt[i] = 0; exp_cnt[i] = 16'((i + 1) * 3); end
        load_chain();
        run_frame(0, 100, -1, -1, 17);
        n_checks++; if (nwords !== 14) begin n_fail++; $display("FAIL abort_nwords: %0d want 14", nwords); end
        n_checks++; if (w_idx[13] !== 5'd18 || w_cnt[13] !== exp_cnt[18]) begin
            n_fail++; $display("FAIL abort_last_word: idx=%0d cnt=%h want 18 %h", w_idx[13], w_cnt[13], exp_cnt[18]); end
        n_checks++; if ({hc_ce, hc_ld, hc_clr, m_valid, busy, done} !== 6'b0) begin
            n_fail++; $display("FAIL abort_async_ctrl: {ce,ld,clr,valid,busy,done}=%b want 000000",
                               {hc_ce, hc_ld, hc_clr, m_valid, busy, done}); end
        n_checks++; if (m_data !== 22'h0) begin n_fail++; $display("FAIL abort_async_data: m_data=%h want 0", m_data); end
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: busy=%b valid=%b want 0 0", busy, m_valid); end
        clr_hist = 1'b1;
        clr_cyc = 0; valid_cyc = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            clr_hist = 1'b0;
            if (hc_clr) clr_cyc++;
            if (busy) valid_cyc++;
        end
        n_checks++; if (clr_cyc !== 1 || valid_cyc !== 0) begin
            n_fail++; $display("FAIL abort_clr_hist: hc_clr cycles=%0d busy cycles=%0d want 1 0", clr_cyc, valid_cyc); end
        run_frame(0, 100, -1, -1, -1);
        n_checks++; if (nwords !== 32) begin n_fail++; $display("FAIL abort_clean_nwords: %0d want 32", nwords); end
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (w_idx[k] !== 5'(31 - k) || w_cnt[k] !== 16'h0) begin
                n_fail++;
                $display("FAIL abort_clean_word%0d: got idx=%0d cnt=%h want idx=%0d cnt=0000",
                         k, w_idx[k], w_cnt[k], 31 - k);
            end
        end
    endtask

    task automatic test_back_to_back();
        int busy_cyc;
        for (int i = 0; i < 32; i++) begin tgt[i] = 0; exp_cnt[i] = 16'(i + 100); end
        load_chain();
        @(negedge clk);
        clr_hist = 1'b1; start = 1'b1; window_len = 24'd50;
        clr_cyc = 0; busy_cyc = 0; ce_cyc = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            clr_hist = 1'b0; start = 1'b0;
            if (hc_clr) clr_cyc++;
            if (busy) busy_cyc++;
            if (hc_ce) ce_cyc++;
        end
        n_checks++; if (clr_cyc !== 1) begin n_fail++; $display("FAIL clr_start_clr: hc_clr cycles=%0d want 1", clr_cyc); end
        n_checks++; if (busy_cyc !== 0 || ce_cyc !== 0) begin
            n_fail++; $display("FAIL clr_start_dropped: busy=%0d ce=%0d want 0 0", busy_cyc, ce_cyc); end
        // Start/clear pulses during ACQ must not restart or clear anything.
        run_frame(30, 100, -1, 12, -1);
        n_checks++; if (ce_cyc !== 30) begin n_fail++; $display("FAIL busy_start_ignored: ce cycles=%0d want 30", ce_cyc); end
        n_checks++; if (clr_cyc !== 0) begin n_fail++; $display("FAIL busy_clr_ignored: hc_clr cycles=%0d want 0", clr_cyc); end
        n_checks++; if (nwords !== 32) begin n_fail++; $display("FAIL busy_nwords: %0d want 32", nwords); end
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (w_idx[k] !== 5'(31 - k) || w_cnt[k] !== 16'h0) begin
                n_fail++;
                $display("FAIL clr_start_word%0d: got idx=%0d cnt=%h want idx=%0d cnt=0000",
                         k, w_idx[k], w_cnt[k], 31 - k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_saturate();
        test_zero_window();
        test_stop();
        test_reset_abort();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hist_readout.md
Name: hist_readout

Overview:
- Control and unload engine for the 32-slice hit-counter chain.
- Runs a timed acquisition window by driving the chain's count enable, then freezes it.
- Unloads all slice counts by pulsing the chain's parallel-load shift, one 16-bit word per slice.
- Presents each count on a valid/ready stream toward the readout FIFO; the unload leaves the chain zeroed.

Parameters:
- NSLICE, 32: number of chained slice counters (one ld per slice).
- CW, 16: counter width, equal to the width of hc_q.
- TW, 24: acquisition window timer width.
- IW, 5: slice index width, equal to clog2(NSLICE).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- clr_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins acquire+unload when IDLE, ignored otherwise.
- stop  in  1  pulse; ends ACQ early.
- clr_hist  in  1  pulse; in IDLE, clears the chain.
- window_len  in  TW  acquisition length in cycles, sampled on the start cycle.
- hc_q  in  CW  chain output (last counter).
- hc_max  in  1  chain saturation flag.
- hc_ce  out  1  chain count enable.
- hc_ld  out  1  chain shift/load pulse.
- hc_clr  out  1  chain synchronous clear.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  1+IW+CW  word = {sat, idx, count}.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of unload.

Behaviour:
- Reset (clr_n low, asynchronous): state=IDLE; hc_ce, hc_ld, hc_clr, m_valid, done and busy all 0; m_data 0; sat 0; idx 0; timer 0.
- Reset mid-operation aborts immediately. The chain keeps its partial contents; software issues clr_hist afterwards.
- All outputs are registered (Moore).
- IDLE:
  - clr_hist: hc_clr=1 for exactly one cycle; clr_hist wins over a same-cycle start, which is dropped.
  - start with window_len>0: load timer=window_len, sat=0, go to ACQ.
  - start with window_len==0: go straight to SETTLE (unload existing counts).
- ACQ:
  - hc_ce=1. Timer decrements each cycle.
  - Exit to SETTLE when the timer reaches 1, on stop, or on hc_max; hc_ce is high for exactly window_len cycles when none of the early exits occur.
  - sat latches 1 if hc_max is seen in ACQ and stays set for the whole frame.
- SETTLE:
  - hc_ce=0 for 2 cycles, covering the chain's negedge hit register plus counter update.
  - sat |= hc_max on the last SETTLE cycle.
  - Then idx=NSLICE-1, go to PRESENT.
- PRESENT:
  - m_valid=1, m_data={sat, idx, hc_q}; m_data is stable while m_valid && !m_ready.
  - On m_valid&&m_ready: go to SHIFT.
- SHIFT:
  - m_valid=0, hc_ld=1 for exactly this cycle; the chain shifts at the closing edge.
  - If idx==0, go to DONE; else idx-=1 and go to PRESENT, where hc_q now holds the next slice.
- DONE: done=1 for one cycle, then IDLE.
- Word order: first word is slice NSLICE-1 (idx 31), last is slice 0 (idx 0).
- Exactly NSLICE words and NSLICE hc_ld pulses per frame. The final ld shifts zero into the last counter, so the chain is all zero after DONE.
- Throughput: one word per 2 cycles maximum (m_ready held high).
- hc_ld and hc_ce are never high together; hc_clr is asserted only in IDLE.
- start, stop and clr_hist outside their stated states are ignored.

Decomposition:
- Shared package hist_pkg:
  - state enum {IDLE, ACQ, SETTLE, PRESENT, SHIFT, DONE};
  - NSLICE, CW and IW constants;
  - m_data field offsets (SAT_BIT, IDX_LSB, CNT_LSB).
- One sub-module, acq_timer: loadable TW-bit down-counter with load, dec and expire outputs.

Test Plan:
- Hits injected on slices 0/5/31 with counts 3/7/1, window_len=100, m_ready=1 -> hc_ce high exactly 100 cycles; words idx31=1, idx5=7, idx0=3, all others 0, sat=0; done once; second unload yields all zeros.
- m_ready toggled randomly with 40% duty -> m_data never changes while stalled; exactly 32 hc_ld pulses; no lost or duplicated idx.
- Slice 2 driven to 0xFFFF so hc_max rises mid-window -> ACQ exits the cycle after hc_max; every word has sat=1; idx2 count = 0xFFFF.
- start with window_len=0 after a prior acquisition -> no hc_ce cycle; 32 words match the prior counts.
- clr_n pulsed low while in PRESENT at idx=17 -> all outputs 0 asynchronously, state IDLE; clr_hist then yields one hc_clr cycle; next frame is clean.
- clr_hist and start asserted in the same IDLE cycle -> hc_clr=1 one cycle, busy stays 0; start asserted while busy -> ignored, window unchanged.
